// File: rtl/run_ctrl_pkg.sv
// ============================================================================
//  Module   : run_ctrl_pkg
//  Purpose  : Shared state encoding and default sizing for core_run_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } run_state_t;

   localparam int CW_DEF         = 16;
   localparam int RST_HOLD_DEF   = 2;
   localparam int MAX_CYCLES_DEF = 1000;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up counter with synchronous clear that sticks at all-ones.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_q <= '0;
      end else if (en && (r_q != '1)) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/core_run_ctrl.sv
// ============================================================================
//  Module   : core_run_ctrl
//  Purpose  : Four-phase run handshake that resets, runs and times a core.
//             Optional timeout enabled by macro RUN_CTRL_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module core_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int CW         = CW_DEF,
   parameter int RST_HOLD   = RST_HOLD_DEF,
   parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          core_done,
   output logic          core_reset,
   output logic          busy,
   output logic          ack,
   output logic          timeout,
   output logic [CW-1:0] cycle_count
);

   localparam logic [3:0] c_hold_last = 4'(RST_HOLD - 1);

   generate
      if ((RST_HOLD < 1) || (RST_HOLD > 15)) begin : g_chk_hold
         $error("core_run_ctrl: RST_HOLD out of range");
      end
      if ((MAX_CYCLES < 1) || (MAX_CYCLES > ((2 ** CW) - 1))) begin : g_chk_max
         $error("core_run_ctrl: MAX_CYCLES out of range");
      end
   endgenerate

   run_state_t    r_state;
   run_state_t    w_next;
   logic [3:0]    r_hold;
   logic [3:0]    w_hold_next;
   logic          w_clr;
   logic          w_en;
   logic          r_core_reset;
   logic          r_busy;
   logic          r_ack;
   logic [CW-1:0] w_count;

`ifdef RUN_CTRL_TIMEOUT_EN
   localparam logic [CW-1:0] c_max_cycles = CW'(MAX_CYCLES);
   logic w_to_set;
   logic r_timeout;
`endif

   always_comb begin
      w_next      = r_state;
      w_hold_next = r_hold;
      w_clr       = 1'b0;
      w_en        = 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
      w_to_set    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (req) begin
               w_next      = HOLD;
               w_hold_next = '0;
               w_clr       = 1'b1;
            end
         end
         HOLD: begin
            if (r_hold == c_hold_last) begin
               w_next = RUN;
            end else begin
               w_hold_next = r_hold + 4'd1;
            end
         end
         RUN: begin
            // done wins over a coincident timeout and freezes the count
            if (core_done) begin
               w_next = DONE;
            end
`ifdef RUN_CTRL_TIMEOUT_EN
            else if (w_count == c_max_cycles) begin
               w_next   = DONE;
               w_to_set = 1'b1;
            end
`endif
            else begin
               w_en = 1'b1;
            end
         end
         DONE: begin
            if (!req) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_hold       <= '0;
         r_core_reset <= 1'b1;
         r_busy       <= 1'b0;
         r_ack        <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_hold       <= w_hold_next;
         r_core_reset <= (w_next != RUN);
         r_busy       <= (w_next == HOLD) || (w_next == RUN);
         r_ack        <= (w_next == DONE);
      end
   end

`ifdef RUN_CTRL_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset || w_clr) begin
         r_timeout <= 1'b0;
      end else if (w_to_set) begin
         r_timeout <= 1'b1;
      end
   end

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   sat_counter #(
      .W (CW)
   ) u_cycle_cnt (
      .clk (clk),
      .clr (reset | w_clr),
      .en  (w_en),
      .q   (w_count)
   );

   assign core_reset  = r_core_reset;
   assign busy        = r_busy;
   assign ack         = r_ack;
   assign cycle_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
// ============================================================================
//  Module   : tb_core_run_ctrl
//  Purpose  : Directed self-checking bench for core_run_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_core_run_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, core_done;
   logic        core_reset, busy, ack, timeout;
   logic [15:0] cycle_count;
   logic        req2, done2;
   logic        core_reset2, busy2, ack2, timeout2;
   logic [3:0]  cycle_count2;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   core_run_ctrl u_dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .core_done   (core_done),
      .core_reset  (core_reset),
      .busy        (busy),
      .ack         (ack),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   core_run_ctrl #(
      .CW         (4),
      .RST_HOLD   (2),
      .MAX_CYCLES (15)
   ) u_dut_sat (
      .clk         (clk),
      .reset       (reset),
      .req         (req2),
      .core_done   (done2),
      .core_reset  (core_reset2),
      .busy        (busy2),
      .ack         (ack2),
      .timeout     (timeout2),
      .cycle_count (cycle_count2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; core_done = 1'b0; req2 = 1'b0; done2 = 1'b0;
      tick(2);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_count", cycle_count, 0);
      chk("rst_sat_count", cycle_count2, 0);
      reset = 1'b0;
      tick(1);

      // normal run: done on the 10th RUN cycle
      req = 1'b1;
      tick(1);
      chk("nrm_hold1_core_reset", core_reset, 1);
      chk("nrm_hold1_busy", busy, 1);
      tick(1);
      chk("nrm_hold2_core_reset", core_reset, 1);
      tick(1);
      chk("nrm_run_core_reset", core_reset, 0);
      chk("nrm_run_count0", cycle_count, 0);
      tick(9);
      chk("nrm_run_count9", cycle_count, 9);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      chk("nrm_ack", ack, 1);
      chk("nrm_count", cycle_count, 9);
      chk("nrm_timeout", timeout, 0);
      chk("nrm_busy", busy, 0);
      chk("nrm_done_core_reset", core_reset, 1);
      tick(1);
      chk("nrm_ack_held", ack, 1);
      req = 1'b0;
      tick(1);
      chk("nrm_ack_drop", ack, 0);
      chk("nrm_count_hold", cycle_count, 9);

      // stale done held through HOLD
      core_done = 1'b1;
      req = 1'b1;
      tick(3);
      chk("stale_in_run", core_reset, 0);
      chk("stale_busy", busy, 1);
      tick(1);
      chk("stale_ack", ack, 1);
      chk("stale_count", cycle_count, 0);
      core_done = 1'b0;
      req = 1'b0;
      tick(1);
      chk("stale_idle_ack", ack, 0);

      // reset at RUN cycle 50
      req = 1'b1;
      tick(3);
      tick(49);
      chk("mid_count49", cycle_count, 49);
      reset = 1'b1;
      tick(1);
      chk("mid_core_reset", core_reset, 1);
      chk("mid_count", cycle_count, 0);
      chk("mid_busy", busy, 0);
      reset = 1'b0;
      req = 1'b0;
      tick(1);
      chk("mid_idle_busy", busy, 0);

      // req dropped during the run
      req = 1'b1;
      tick(1);
      req = 1'b0;
      tick(2);
      chk("early_run_busy", busy, 1);
      tick(4);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      chk("early_ack", ack, 1);
      chk("early_count", cycle_count, 4);
      tick(1);
      chk("early_ack_once", ack, 0);
      chk("early_busy_idle", busy, 0);

`ifdef RUN_CTRL_TIMEOUT_EN
      req = 1'b1;
      tick(3);
      tick(1000);
      chk("to_count_at_max", cycle_count, 1000);
      chk("to_still_busy", busy, 1);
      tick(1);
      chk("to_ack", ack, 1);
      chk("to_timeout", timeout, 1);
      chk("to_count", cycle_count, 1000);
      req = 1'b0;
      tick(1);
      chk("to_timeout_hold", timeout, 1);
      req = 1'b1;
      tick(1);
      chk("tie_timeout_clr", timeout, 0);
      tick(2);
      tick(1000);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      chk("tie_ack", ack, 1);
      chk("tie_timeout", timeout, 0);
      chk("tie_count", cycle_count, 1000);
      req = 1'b0;
      tick(1);
`else
      req = 1'b1;
      tick(3);
      tick(5000);
      chk("noto_busy", busy, 1);
      chk("noto_timeout", timeout, 0);
      chk("noto_count", cycle_count, 5000);
      req = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      chk("noto_idle", busy, 0);
`endif

      // saturation on a 4-bit counter, done at RUN cycle 20
      req2 = 1'b1;
      tick(3);
      chk("sat_run", core_reset2, 0);
      tick(19);
      done2 = 1'b1;
      tick(1);
      done2 = 1'b0;
      chk("sat_ack", ack2, 1);
      chk("sat_count", cycle_count2, 15);
`ifdef RUN_CTRL_TIMEOUT_EN
      chk("sat_timeout", timeout2, 1);
`else
      chk("sat_timeout", timeout2, 0);
`endif
      req2 = 1'b0;
      tick(1);
      chk("sat_ack_drop", ack2, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 16, giving the cycle counter width.
REQ-002 The block SHALL have parameter RST_HOLD, default 2, giving the number of cycles core_reset is held during start (legal range 1..15).
REQ-003 The block SHALL have parameter MAX_CYCLES, default 1000, giving the timeout limit in core run cycles (legal range 1..2^CW-1).
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, width 1: run request from the harness, a level used in a four-phase handshake.
REQ-007 The block SHALL have port core_done, input, width 1: done flag from the processor top level.
REQ-008 The block SHALL have port core_reset, output, width 1: reset driven into the processor top level.
REQ-009 The block SHALL have port busy, output, width 1: high in HOLD and RUN.
REQ-010 The block SHALL have port ack, output, width 1: run complete, high in DONE.
REQ-011 The block SHALL have port timeout, output, width 1: the last run ended by timeout rather than by core_done.
REQ-012 The block SHALL have port cycle_count, output, width CW: core run cycles of the current or last run.

Function
REQ-013 The FSM SHALL have states IDLE, HOLD, RUN and DONE; all outputs SHALL be registered.
REQ-014 IDLE: core_reset=1, busy=0, ack=0; when req=1 the FSM SHALL go to HOLD, clearing cycle_count and timeout on the same edge.
REQ-015 HOLD: core_reset=1, busy=1; an internal hold counter SHALL count RST_HOLD cycles, then the FSM SHALL go to RUN.
REQ-016 RUN: core_reset=0, busy=1; cycle_count SHALL increment by 1 every cycle spent in RUN, so the first RUN cycle yields 1.
REQ-017 core_done SHALL be sampled only in RUN; it SHALL be ignored in IDLE, HOLD and DONE, because a stale done can exist while the core is held in reset.
REQ-018 When core_done=1 in RUN, the FSM SHALL go to DONE, and cycle_count SHALL NOT increment on that edge.
REQ-019 DONE: core_reset=1, busy=0, ack=1; cycle_count and timeout SHALL hold; when req=0 the FSM SHALL go to IDLE and ack SHALL drop on the same edge.
REQ-020 If req falls during HOLD or RUN, the run SHALL continue to DONE; ack SHALL then be high for exactly one cycle before the return to IDLE.
REQ-021 If req stays high in IDLE after a completed handshake, a new run SHALL start; the harness is responsible for the low phase.
REQ-022 cycle_count SHALL saturate at 2^CW-1 and never wrap.

Reset
REQ-023 On reset=1 at a clock edge, from any state including mid-run, the block SHALL enter IDLE with core_reset=1, busy=0, ack=0, timeout=0 and cycle_count=0.
REQ-024 No output SHALL depend combinationally on reset.

Configuration
REQ-025 With macro RUN_CTRL_TIMEOUT_EN defined, RUN SHALL go to DONE with timeout=1 when cycle_count reaches MAX_CYCLES and core_done=0; if core_done=1 on that same cycle, it SHALL take priority and timeout SHALL be 0.
REQ-026 Without RUN_CTRL_TIMEOUT_EN, no timeout logic SHALL exist, the timeout output SHALL be tied to 0, and RUN SHALL exit only on core_done or reset.

Structure
REQ-027 Package run_ctrl_pkg SHALL hold the state enum (run_state_t: IDLE, HOLD, RUN, DONE) and the default constants for CW, RST_HOLD and MAX_CYCLES.
REQ-028 The cycle counter SHALL be a sub-module sat_counter (parameter W; ports clk, clr, en, q) that saturates at all-ones; the FSM and hold counter SHALL stay in core_run_ctrl.

Verification
REQ-029 Scenario (normal run): reset, then req=1 with core_done pulsed at the 10th RUN cycle -> core_reset=1 for exactly 2 cycles after the IDLE exit; ack=1 with cycle_count=9 and timeout=0; ack drops on the edge after req=0.
REQ-030 Scenario (stale done): core_done held at 1 before and during HOLD -> the FSM still enters RUN, then exits to DONE after the first RUN-cycle sample, with cycle_count=0.
REQ-031 Scenario (timeout, macro on): MAX_CYCLES=1000 and core_done never asserted -> DONE with timeout=1 and cycle_count=1000; with the macro off -> still busy after 5000 cycles.
REQ-032 Scenario (done/timeout tie, macro on): core_done=1 on the cycle cycle_count reaches 1000 -> timeout=0.
REQ-033 Scenario (mid-run reset): reset=1 at RUN cycle 50 -> next cycle IDLE, core_reset=1, cycle_count=0, busy=0.
REQ-034 Scenario (early req drop and saturation): req dropped in RUN -> ack=1 for one cycle only; CW=4 with done at cycle 20 -> cycle_count=15.
